// File: rtl/crc_rsp_process.sv
// crc_rsp_process: completion side of the CRC parameter channel.
// Issues one descriptor at a time to the CRC engine, retries on error, and returns a response.
module crc_rsp_process #(
    parameter int REQ_ID_W = 4,
    parameter int RPT_W    = 3,
    parameter int PARAM_W  = 64 + 2 + 32 + 32 + RPT_W + REQ_ID_W
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_crc_params_valid,
    output logic                o_crc_params_ready,
    input  logic [PARAM_W-1:0]  i_crc_params_data,
    output logic                o_eng_cmd_valid,
    input  logic                i_eng_cmd_ready,
    output logic [63:0]         o_eng_cmd_poly,
    output logic [1:0]          o_eng_cmd_size_sel,
    output logic [31:0]         o_eng_cmd_data_addr,
    output logic [31:0]         o_eng_cmd_crc_addr,
    input  logic                i_eng_done,
    input  logic                i_eng_err,
    output logic                o_rsp_valid,
    input  logic                i_rsp_ready,
    output logic [REQ_ID_W-1:0] o_rsp_id,
    output logic                o_rsp_err,
    output logic [RPT_W:0]      o_rsp_attempts,
    output logic                o_outstand_dec,
    output logic                o_busy
);
    localparam int RPT_LSB  = REQ_ID_W;
    localparam int CRC_LSB  = RPT_LSB + RPT_W;
    localparam int DAT_LSB  = CRC_LSB + 32;
    localparam int SZ_LSB   = DAT_LSB + 32;
    localparam int POLY_LSB = SZ_LSB + 2;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

    state_e             state_q, state_d;
    logic [PARAM_W-1:0] desc_q, desc_d;
    logic [RPT_W-1:0]   retry_q, retry_d;
    logic               rdy_q, rdy_d;
    logic               cmd_vld_q, cmd_vld_d;
    logic               rsp_vld_q, rsp_vld_d;
    logic               rsp_err_q, rsp_err_d;
    logic [RPT_W:0]     rsp_att_q, rsp_att_d;
    logic               dec_q, dec_d;
    logic               busy_q, busy_d;
    logic [RPT_W-1:0]   rpt_num;

    assign rpt_num = desc_q[RPT_LSB +: RPT_W];

    always_comb begin
        state_d   = state_q;
        desc_d    = desc_q;
        retry_d   = retry_q;
        rsp_err_d = rsp_err_q;
        rsp_att_d = rsp_att_q;
        case (state_q)
            IDLE: if (i_crc_params_valid && rdy_q) begin
                desc_d  = i_crc_params_data;
                retry_d = '0;
                state_d = ISSUE;
            end
            ISSUE: if (i_eng_cmd_ready) state_d = WAIT;
            WAIT: if (i_eng_done) begin
                if (i_eng_err && retry_q < rpt_num) begin
                    retry_d = retry_q + RPT_W'(1);
                    state_d = ISSUE;
                end else begin
                    rsp_err_d = i_eng_err;
                    rsp_att_d = (RPT_W+1)'(retry_q) + (RPT_W+1)'(1);
                    state_d   = RESP;
                end
            end
            RESP: if (i_rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Output flags follow the next state so every output is a plain flop.
        rdy_d     = state_d == IDLE;
        cmd_vld_d = state_d == ISSUE;
        rsp_vld_d = state_d == RESP;
        busy_d    = state_d != IDLE;
        dec_d     = state_q == RESP && i_rsp_ready;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q   <= IDLE;
            desc_q    <= '0;
            retry_q   <= '0;
            rdy_q     <= 1'b1;
            cmd_vld_q <= 1'b0;
            rsp_vld_q <= 1'b0;
            rsp_err_q <= 1'b0;
            rsp_att_q <= '0;
            dec_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            desc_q    <= desc_d;
            retry_q   <= retry_d;
            rdy_q     <= rdy_d;
            cmd_vld_q <= cmd_vld_d;
            rsp_vld_q <= rsp_vld_d;
            rsp_err_q <= rsp_err_d;
            rsp_att_q <= rsp_att_d;
            dec_q     <= dec_d;
            busy_q    <= busy_d;
        end
    end

    assign o_crc_params_ready  = rdy_q;
    assign o_eng_cmd_valid     = cmd_vld_q;
    assign o_eng_cmd_poly      = desc_q[POLY_LSB +: 64];
    assign o_eng_cmd_size_sel  = desc_q[SZ_LSB +: 2];
    assign o_eng_cmd_data_addr = desc_q[DAT_LSB +: 32];
    assign o_eng_cmd_crc_addr  = desc_q[CRC_LSB +: 32];
    assign o_rsp_valid         = rsp_vld_q;
    assign o_rsp_id            = desc_q[REQ_ID_W-1:0];
    assign o_rsp_err           = rsp_err_q;
    assign o_rsp_attempts      = rsp_att_q;
    assign o_outstand_dec      = dec_q;
    assign o_busy              = busy_q;
endmodule

// File: tb/tb_crc_rsp_process.sv
// tb_crc_rsp_process: directed bench with a descriptor-level model checked every cycle.
module tb_crc_rsp_process;
    localparam int IW = 4, RW = 3, PW = 64 + 2 + 32 + 32 + RW + IW;

    logic          i_clk = 1'b0, i_reset = 1'b1;
    logic          i_crc_params_valid = 1'b0, i_eng_cmd_ready = 1'b0;
    logic          i_eng_done = 1'b0, i_eng_err = 1'b0, i_rsp_ready = 1'b0;
    logic [PW-1:0] i_crc_params_data = '0;
    logic          o_crc_params_ready, o_eng_cmd_valid, o_rsp_valid, o_rsp_err;
    logic          o_outstand_dec, o_busy;
    logic [63:0]   o_eng_cmd_poly;
    logic [1:0]    o_eng_cmd_size_sel;
    logic [31:0]   o_eng_cmd_data_addr, o_eng_cmd_crc_addr;
    logic [IW-1:0] o_rsp_id;
    logic [RW:0]   o_rsp_attempts;

    crc_rsp_process dut (
        .i_clk(i_clk), .i_reset(i_reset),
        .i_crc_params_valid(i_crc_params_valid), .o_crc_params_ready(o_crc_params_ready),
        .i_crc_params_data(i_crc_params_data),
        .o_eng_cmd_valid(o_eng_cmd_valid), .i_eng_cmd_ready(i_eng_cmd_ready),
        .o_eng_cmd_poly(o_eng_cmd_poly), .o_eng_cmd_size_sel(o_eng_cmd_size_sel),
        .o_eng_cmd_data_addr(o_eng_cmd_data_addr), .o_eng_cmd_crc_addr(o_eng_cmd_crc_addr),
        .i_eng_done(i_eng_done), .i_eng_err(i_eng_err),
        .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready),
        .o_rsp_id(o_rsp_id), .o_rsp_err(o_rsp_err), .o_rsp_attempts(o_rsp_attempts),
        .o_outstand_dec(o_outstand_dec), .o_busy(o_busy)
    );

    always #5 i_clk = ~i_clk;

    int compared = 0, mismatched = 0;
    int cyc = 0, n_cmd = 0, n_dec = 0, t_acc = 0;
    logic          in_flight = 1'b0, prev_dec = 1'b0;
    logic [63:0]   m_poly;
    logic [1:0]    m_sz;
    logic [31:0]   m_da, m_ca;
    logic [IW-1:0] m_id;
    logic          m_err;
    logic [RW:0]   m_att;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge i_clk) begin
        cyc <= cyc + 1;
        if (!i_reset && o_eng_cmd_valid && i_eng_cmd_ready) n_cmd <= n_cmd + 1;
        if (!i_reset && o_outstand_dec) n_dec <= n_dec + 1;
    end

    // Per-cycle compare against the descriptor currently in flight.
    always @(negedge i_clk) begin
        if (!i_reset) begin
            chk("ready_eq_not_busy", o_crc_params_ready, !o_busy);
            chk("cmd_rsp_exclusive", o_eng_cmd_valid && o_rsp_valid, 0);
            if (o_eng_cmd_valid) begin
                chk("cmd_in_flight", in_flight, 1);
                chk("cmd_poly", o_eng_cmd_poly, m_poly);
                chk("cmd_size", o_eng_cmd_size_sel, m_sz);
                chk("cmd_daddr", o_eng_cmd_data_addr, m_da);
                chk("cmd_caddr", o_eng_cmd_crc_addr, m_ca);
            end
            if (o_rsp_valid) begin
                chk("rsp_in_flight", in_flight, 1);
                chk("rsp_id", o_rsp_id, m_id);
                chk("rsp_err", o_rsp_err, m_err);
                chk("rsp_attempts", o_rsp_attempts, m_att);
            end
            if (o_outstand_dec) chk("dec_one_cycle", prev_dec, 0);
        end
        prev_dec = o_outstand_dec && !i_reset;
    end

    task automatic send(input logic [IW-1:0] id, input logic [RW-1:0] rpt, input logic [7:0] errs,
                        input logic [63:0] poly, input logic [1:0] sz,
                        input logic [31:0] da, input logic [31:0] ca);
        int a = 0;
        int t = 0;
        while (!o_crc_params_ready && t < 50) begin @(negedge i_clk); t++; end
        chk("send_ready_wait", o_crc_params_ready, 1);
        while (errs[a] && a < int'(rpt)) a++;
        m_poly = poly; m_sz = sz; m_da = da; m_ca = ca; m_id = id;
        m_err = errs[a]; m_att = (RW+1)'(a + 1); in_flight = 1'b1;
        i_crc_params_data = {poly, sz, da, ca, rpt, id};
        i_crc_params_valid = 1'b1;
        t_acc = cyc;
        @(negedge i_clk);
        i_crc_params_valid = 1'b0;
    endtask

    task automatic engine(input logic [7:0] errs, input int dly);
        int k = 0;
        bit fin = 0;
        while (!fin && k < 8) begin
            int t = 0;
            while (!o_eng_cmd_valid && t < 50) begin @(negedge i_clk); t++; end
            chk("cmd_valid_wait", o_eng_cmd_valid, 1);
            for (int i = 0; i < dly; i++) begin
                chk("params_ready_low", o_crc_params_ready, 0);
                @(negedge i_clk);
                chk("cmd_held", o_eng_cmd_valid, 1);
            end
            i_eng_cmd_ready = 1'b1;
            @(negedge i_clk);
            i_eng_cmd_ready = 1'b0;
            chk("cmd_drop", o_eng_cmd_valid, 0);
            i_eng_done = 1'b1; i_eng_err = errs[k];
            @(negedge i_clk);
            i_eng_done = 1'b0; i_eng_err = 1'b0;
            k++;
            fin = o_rsp_valid;
        end
    endtask

    task automatic respond(input int dly);
        int t = 0;
        while (!o_rsp_valid && t < 50) begin @(negedge i_clk); t++; end
        chk("rsp_valid_wait", o_rsp_valid, 1);
        for (int i = 0; i < dly; i++) begin
            chk("bp_params_ready", o_crc_params_ready, 0);
            chk("bp_no_dec", o_outstand_dec, 0);
            @(negedge i_clk);
        end
        i_rsp_ready = 1'b1;
        @(negedge i_clk);
        i_rsp_ready = 1'b0;
        in_flight = 1'b0;
        chk("rsp_drop", o_rsp_valid, 0);
        chk("dec_pulse", o_outstand_dec, 1);
        chk("ready_after_rsp", o_crc_params_ready, 1);
        chk("idle_after_rsp", o_busy, 0);
        @(negedge i_clk);
        chk("dec_ends", o_outstand_dec, 0);
    endtask

    initial begin
        int c0, d0;
        repeat (2) @(negedge i_clk);
        chk("rst_ready", o_crc_params_ready, 1);
        chk("rst_cmd_valid", o_eng_cmd_valid, 0);
        chk("rst_rsp_valid", o_rsp_valid, 0);
        chk("rst_dec", o_outstand_dec, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_poly", o_eng_cmd_poly, 0);
        chk("rst_attempts", o_rsp_attempts, 0);
        i_reset = 1'b0;
        @(negedge i_clk);

        c0 = n_cmd; d0 = n_dec;
        send(4'd5, 3'd0, 8'h00, 64'h0000_0000_04C1_1DB7, 2'd2, 32'h1000_0000, 32'h2000_0000);
        engine(8'h00, 0);
        chk("t1_latency", cyc - t_acc, 3);
        chk("t1_id_lit", o_rsp_id, 5);
        chk("t1_err_lit", o_rsp_err, 0);
        chk("t1_att_lit", o_rsp_attempts, 1);
        respond(0);
        chk("t1_cmds", n_cmd - c0, 1);
        chk("t1_decs", n_dec - d0, 1);

        c0 = n_cmd;
        send(4'd3, 3'd2, 8'h03, 64'hAD93_D235_94C9_35A9, 2'd3, 32'hDEAD_BEE0, 32'hCAFE_F00C);
        engine(8'h03, 0);
        chk("t2_att_lit", o_rsp_attempts, 3);
        chk("t2_err_lit", o_rsp_err, 0);
        respond(0);
        chk("t2_cmds", n_cmd - c0, 3);

        c0 = n_cmd;
        send(4'd7, 3'd1, 8'hFF, 64'h0000_0000_0000_8005, 2'd1, 32'h0000_0040, 32'h0000_0080);
        engine(8'hFF, 0);
        chk("t3_att_lit", o_rsp_attempts, 2);
        chk("t3_err_lit", o_rsp_err, 1);
        respond(1);
        chk("t3_cmds", n_cmd - c0, 2);

        c0 = n_cmd; d0 = n_dec;
        send(4'd12, 3'd7, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, 2'd0, 32'hFFFF_FFFC, 32'h8000_0000);
        engine(8'hFF, 0);
        chk("t4_att_lit", o_rsp_attempts, 8);
        respond(0);
        chk("t4_cmds", n_cmd - c0, 8);

        c0 = n_cmd; d0 = n_dec;
        send(4'd10, 3'd0, 8'h00, 64'h1234_5678_9ABC_DEF0, 2'd2, 32'h0BAD_0000, 32'h0000_0BAD);
        engine(8'h00, 4);
        respond(5);
        repeat (3) @(negedge i_clk);
        chk("t5_cmds", n_cmd - c0, 1);
        chk("t5_decs", n_dec - d0, 1);
        i_eng_done = 1'b1; i_eng_err = 1'b1;
        @(negedge i_clk);
        i_eng_done = 1'b0; i_eng_err = 1'b0;
        @(negedge i_clk);
        chk("spur_busy", o_busy, 0);
        chk("spur_rsp", o_rsp_valid, 0);
        chk("spur_ready", o_crc_params_ready, 1);

        c0 = n_cmd; d0 = n_dec;
        send(4'd9, 3'd3, 8'hFF, 64'h0000_0000_0000_0007, 2'd0, 32'h0000_1111, 32'h0000_2222);
        while (!o_eng_cmd_valid) @(negedge i_clk);
        i_eng_cmd_ready = 1'b1;
        @(negedge i_clk);
        i_eng_cmd_ready = 1'b0;
        chk("t6_in_wait", o_busy, 1);
        i_reset = 1'b1;
        in_flight = 1'b0;
        @(negedge i_clk);
        i_reset = 1'b0;
        chk("t6_rst_busy", o_busy, 0);
        chk("t6_rst_ready", o_crc_params_ready, 1);
        chk("t6_rst_cmd", o_eng_cmd_valid, 0);
        chk("t6_rst_rsp", o_rsp_valid, 0);
        i_eng_done = 1'b1;
        @(negedge i_clk);
        i_eng_done = 1'b0;
        repeat (4) @(negedge i_clk);
        chk("t6_no_dec", n_dec - d0, 0);
        chk("t6_no_rsp", o_rsp_valid, 0);
        send(4'd2, 3'd1, 8'h01, 64'h0000_0000_EDB8_8320, 2'd2, 32'h0000_3000, 32'h0000_4000);
        engine(8'h01, 1);
        chk("t6_att_lit", o_rsp_attempts, 2);
        chk("t6_id_lit", o_rsp_id, 2);
        respond(2);
        chk("t6_decs", n_dec - d0, 1);
        chk("t6_cmds", n_cmd - c0, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
